// File: rtl/ext_unit_if.sv
// Decode-stage immediate-extender bus: raw immediate and op select in, extended values out.
interface ext_unit_if;
    logic [15:0] in;
    logic [1:0]  EXTOp;
    logic        en;
    logic [31:0] out;
    logic [31:0] out_q;
    logic        out_valid;

    modport master (
        output in,
        output EXTOp,
        output en,
        input  out,
        input  out_q,
        input  out_valid
    );

    modport slave (
        input  in,
        input  EXTOp,
        input  en,
        output out,
        output out_q,
        output out_valid
    );
endinterface

// File: rtl/ext_unit.sv
// MIPS immediate extender: zero/sign/LUI/branch-offset widening of a 16-bit immediate,
// with a combinational result for decode and an enabled, valid-flagged copy for ID/EX.
module ext_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    ext_unit_if.slave   bus
);

    localparam logic [1:0] EXT_OP_ZERO = 2'b00;
    localparam logic [1:0] EXT_OP_SIGN = 2'b01;
    localparam logic [1:0] EXT_OP_LUI  = 2'b10;
    localparam logic [1:0] EXT_OP_BR   = 2'b11;

    // Encoding is shared with the control unit, so the code values must not change.
    function automatic logic [OUT_W-1:0] f_extend(
        input logic [IN_W-1:0] imm,
        input logic [1:0]      op
    );
        logic [OUT_W-1:0] res;
        case (op)
            EXT_OP_ZERO: res = {16'h0000, imm};
            EXT_OP_SIGN: res = {{16{imm[IN_W-1]}}, imm};
            EXT_OP_LUI:  res = {imm, 16'h0000};
            EXT_OP_BR:   res = {{14{imm[IN_W-1]}}, imm, 2'b00};
            default:     res = {OUT_W{1'b0}};
        endcase
        return res;
    endfunction

    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] r_out_q;
    logic             r_out_valid;

    // Same-cycle extension for decode; independent of clock and reset.
    always_comb begin
        w_ext = f_extend(bus.in, bus.EXTOp);
    end

    // ID/EX capture: reset dominates en, otherwise load on en and hold on !en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q     <= 32'h0000_0000;
            r_out_valid <= 1'b0;
        end else if (bus.en) begin
            r_out_q     <= w_ext;
            r_out_valid <= 1'b1;
        end else begin
            r_out_q     <= r_out_q;
            r_out_valid <= r_out_valid;
        end
    end

    assign bus.out       = w_ext;
    assign bus.out_q     = r_out_q;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_ext_unit.sv
// Self-checking bench for ext_unit: combinational encodings, boundaries, and the
// registered path checked through an expected-value queue.
module tb_ext_unit;

    logic clk;
    logic rst_n;
    ext_unit_if bus();

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_q[$];

    ext_unit #(.IN_W(16), .OUT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference built from arithmetic rather than bit concatenation.
    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] op);
        logic signed [31:0] s;
        s = 32'($signed(imm));
        case (op)
            2'b00:   return 32'(imm);
            2'b01:   return s;
            2'b10:   return 32'(imm) << 16;
            default: return s * 32'sd4;
        endcase
    endfunction

    task automatic chk_out(input string name, input logic [31:0] exp);
        total_cnt++;
        if (bus.out !== exp) $display("FAIL %s: out got %h expected %h", name, bus.out, exp);
        else pass_cnt++;
    endtask

    task automatic chk_reg(input string name, input logic [31:0] exp_q_v, input logic exp_v);
        total_cnt++;
        if (bus.out_q !== exp_q_v || bus.out_valid !== exp_v)
            $display("FAIL %s: out_q/valid got %h/%b expected %h/%b",
                     name, bus.out_q, bus.out_valid, exp_q_v, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.en = 1'b0; bus.in = 16'h1234; bus.EXTOp = 2'b00;
        #1;
        chk_reg("reset_state", 32'h0000_0000, 1'b0);
        chk_out("reset_comb", 32'h0000_1234);
        @(posedge clk); #1;
        chk_reg("reset_held_edge", 32'h0000_0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        bus.in = 16'hFE34; bus.EXTOp = 2'b00; #1;
        chk_out("zero_fe34", 32'h0000_FE34);
        bus.in = 16'hFFFF; #1;
        chk_out("zero_ffff", 32'h0000_FFFF);
    endtask

    task automatic test_sign();
        bus.in = 16'hFE34; bus.EXTOp = 2'b01; #1;
        chk_out("sign_fe34", 32'hFFFF_FE34);
        bus.in = 16'h7FFF; #1;
        chk_out("sign_7fff", 32'h0000_7FFF);
        bus.in = 16'h8000; #1;
        chk_out("sign_8000", 32'hFFFF_8000);
    endtask

    task automatic test_lui();
        bus.in = 16'hFE34; bus.EXTOp = 2'b10; #1;
        chk_out("lui_fe34", 32'hFE34_0000);
        bus.in = 16'h0000; #1;
        chk_out("lui_0000", 32'h0000_0000);
    endtask

    task automatic test_br();
        bus.in = 16'hFFFF; bus.EXTOp = 2'b11; #1;
        chk_out("br_ffff", 32'hFFFF_FFFC);
        bus.in = 16'h0001; #1;
        chk_out("br_0001", 32'h0000_0004);
        bus.in = 16'h8000; #1;
        chk_out("br_8000", 32'hFFFE_0000);
    endtask

    task automatic test_random_comb();
        for (int i = 0; i < 16; i++) begin
            bus.in = 16'($urandom); bus.EXTOp = 2'($urandom_range(0, 3)); #1;
            chk_out("rand_comb", model(bus.in, bus.EXTOp));
        end
    endtask

    task automatic test_registered();
        logic [31:0] e;
        @(negedge clk);
        bus.in = 16'hFE34; bus.EXTOp = 2'b01; bus.en = 1'b1;
        exp_q.push_back(32'hFFFF_FE34);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk_reg("reg_capture", e, 1'b1);
        @(negedge clk);
        bus.en = 1'b0; bus.in = 16'h0001; bus.EXTOp = 2'b00; #1;
        chk_out("hold_comb_tracks", 32'h0000_0001);
        @(posedge clk); #1;
        chk_reg("hold_en0", e, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in = 16'($urandom); bus.EXTOp = 2'($urandom_range(0, 3));
            bus.en = (i % 3 != 2);
            if (bus.en) exp_q.push_back(model(bus.in, bus.EXTOp));
            @(posedge clk); #1;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            chk_reg("b2b", e, 1'b1);
            // Mid-cycle input changes must not disturb the captured value.
            bus.in = ~bus.in; #1;
            chk_reg("b2b_midcycle", e, 1'b1);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.in = 16'h8001; bus.EXTOp = 2'b11; bus.en = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk_reg("async_rst_between_edges", 32'h0000_0000, 1'b0);
        chk_out("async_rst_comb", 32'hFFFE_0004);
        @(posedge clk); #1;
        chk_reg("rst_wins_over_en", 32'h0000_0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; bus.en = 1'b0;
        @(posedge clk); #1;
        chk_reg("post_rst_en0", 32'h0000_0000, 1'b0);
        @(negedge clk);
        bus.en = 1'b1; bus.in = 16'h0000; bus.EXTOp = 2'b10;
        @(posedge clk); #1;
        chk_reg("post_rst_capture_zero", 32'h0000_0000, 1'b1);
        bus.en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_sign();
        test_lui();
        test_br();
        test_random_comb();
        test_registered();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ext_unit.md
Name: ext_unit

Overview:
- Immediate extender in the MIPS datapath decode stage: widens the 16-bit instruction immediate to 32 bits according to a 2-bit operation code.
- Feeds the ALU B-operand mux and the branch-target adder.
- Provides a combinational result for same-cycle use by decode.
- Also provides a registered copy, with a valid flag, for the ID/EX boundary.

Parameters:
- IN_W, 16, immediate input width (fixed; other values unsupported).
- OUT_W, 32, extended output width (fixed; other values unsupported).

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  16  raw immediate field (instr[15:0]).
- EXTOp  input  2  extension operation select.
- en  input  1  capture enable for the registered path.
- out  output  32  combinational extended value.
- out_q  output  32  registered extended value.
- out_valid  output  1  out_q holds a value captured with en=1 since the last reset.

Behaviour:
- EXTOp encoding, shared with the control unit:
  - EXT_OP_ZERO = 2'b00
  - EXT_OP_SIGN = 2'b01
  - EXT_OP_LUI = 2'b10
  - EXT_OP_BR = 2'b11
- ZERO: out = {16'h0000, in}.
- SIGN: out = {{16{in[15]}}, in}.
- LUI: out = {in, 16'h0000}.
- BR: out = {{14{in[15]}}, in, 2'b00}, i.e. the sign-extended value shifted left by 2. The two LSBs are always 0, and bits [31:17] all equal in[15].
- out is purely combinational, with zero latency from in and EXTOp. It settles within the same simulation timestep; no clock is involved.
- out is fully defined for all 4 EXTOp codes. No X propagation when the inputs are known.
- Registered path:
  - On the rising edge of clk with en=1: out_q <= out and out_valid <= 1.
  - With en=0: out_q and out_valid hold their values.
- Reset:
  - While rst_n=0, asynchronously force out_q = 32'h0000_0000 and out_valid = 0, independent of clk.
  - Reset has no effect on the combinational out.
  - Deassertion takes effect at the next rising edge.
  - Reset asserted mid-operation wins over en on the same edge.
- EXTOp or in changing between edges affects only out. out_q samples only at the edge.
- No internal state beyond out_q and out_valid. No handshake or backpressure.
- Boundary values:
  - in=16'h8000 SIGN -> 32'hFFFF_8000.
  - in=16'h7FFF SIGN -> 32'h0000_7FFF.
  - in=16'h0000 LUI -> 32'h0000_0000.
  - in=16'hFFFF ZERO -> 32'h0000_FFFF.

Test Plan:
- Zero-extend: in=16'hFE34, EXTOp=00 -> out=32'h0000_FE34 after 1 ns, with no clock edge.
- Sign-extend: in=16'hFE34, EXTOp=01 -> out=32'hFFFF_FE34. Then in=16'h7FFF -> 32'h0000_7FFF.
- LUI: in=16'hFE34, EXTOp=10 -> out=32'hFE34_0000.
- Branch offset:
  - in=16'hFFFF, EXTOp=11 -> out=32'hFFFF_FFFC.
  - in=16'h0001 -> 32'h0000_0004.
- Registered path:
  - Assert rst_n=0 -> out_q=0 and out_valid=0 immediately.
  - Release reset, set in=16'hFE34, EXTOp=01, en=1, apply one rising edge -> out_q=32'hFFFF_FE34, out_valid=1.
  - Set en=0 and change in -> out_q unchanged while out tracks the new value.
- Async reset mid-run: with out_valid=1, pull rst_n low between edges -> out_q=0 and out_valid=0 before the next edge. out still equals the combinational result.
